sprite_pixel_fifo: RTL and testbench

- Downstream consumer of the sprite OAM/fetch stage.
- Each time that stage finishes fetching one sprite row (tile low/high bytes plus attribute byte), this block merges the 8 pixels into an 8-slot sprite pixel shifter.
- On every PPU pixel clock it shifts out one sprite pixel (colour, palette, BG-priority) to the BG/sprite mixer.
- It resolves sprite-over-sprite overlap for both DMG and GBC rules.

---
 rtl/sprite_pixel_fifo_pkg.sv | 39 +++
 rtl/sprite_pixel_fifo_if.sv | 31 +++
 rtl/sprite_pixel_fifo_slot_merge.sv | 23 ++
 rtl/sprite_pixel_fifo.sv | 78 +++++++
 tb/tb_sprite_pixel_fifo.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/sprite_pixel_fifo_pkg.sv
// Shared types and constants for the sprite pixel shifter: slot layout,
// the transparent slot value, OAM attribute bit positions and row helpers.
package sprite_pixel_fifo_pkg;

  localparam int unsigned DEPTH   = 8;
  localparam int unsigned COLOR_W = 2;
  localparam int unsigned PAL_W   = 3;
  localparam int unsigned IDX_W   = 4;
  localparam int unsigned SKIP_W  = 3;

  localparam int unsigned ATTR_PRIO      = 7;
  localparam int unsigned ATTR_YFLIP     = 6;
  localparam int unsigned ATTR_XFLIP     = 5;
  localparam int unsigned ATTR_DMGPAL    = 4;
  localparam int unsigned ATTR_CGBPAL_HI = 2;
  localparam int unsigned ATTR_CGBPAL_LO = 0;

  typedef struct packed {
    logic [COLOR_W-1:0] color;
    logic [PAL_W-1:0]   palette;
    logic               bg_prio;
    logic [IDX_W-1:0]   index;
  } slot_t;

  // Index 4'hF loses every GBC priority compare, so an empty slot never blocks a real pixel
  localparam slot_t TRANSPARENT = '{color: '0, palette: '0, bg_prio: 1'b0, index: 4'hF};

  function automatic logic [COLOR_W-1:0] row_pixel(input logic [7:0] lo, input logic [7:0] hi,
                                                   input logic xflip, input logic [2:0] p);
    logic [2:0] b;
    b = xflip ? p : 3'(3'd7 - p);
    return {hi[b], lo[b]};
  endfunction

  function automatic logic [PAL_W-1:0] attr_palette(input logic [7:0] attr, input logic is_gbc);
    return is_gbc ? attr[ATTR_CGBPAL_HI:ATTR_CGBPAL_LO] : {2'b00, attr[ATTR_DMGPAL]};
  endfunction

endpackage

// File: rtl/sprite_pixel_fifo_if.sv
// Bus between the sprite fetch stage (master) and the sprite pixel shifter (slave),
// including the pixel stream handed to the BG/sprite mixer.
interface sprite_pixel_fifo_if;

  logic       ce;
  logic       isGBC;
  logic       line_reset;
  logic       load;
  logic [7:0] load_lo;
  logic [7:0] load_hi;
  logic [7:0] load_attr;
  logic [3:0] load_index;
  logic [2:0] load_skip;
  logic       shift;

  logic [1:0] pix_color;
  logic       pix_opaque;
  logic [2:0] pix_palette;
  logic       pix_bg_prio;

  modport master (
    output ce, isGBC, line_reset, load, load_lo, load_hi, load_attr, load_index, load_skip, shift,
    input  pix_color, pix_opaque, pix_palette, pix_bg_prio
  );

  modport slave (
    input  ce, isGBC, line_reset, load, load_lo, load_hi, load_attr, load_index, load_skip, shift,
    output pix_color, pix_opaque, pix_palette, pix_bg_prio
  );

endinterface

// File: rtl/sprite_pixel_fifo_slot_merge.sv
// Combinational overlap resolution for one slot: DMG keeps the first opaque
// pixel, GBC additionally lets a lower OAM index take over.
module sprite_slot_merge
  import sprite_pixel_fifo_pkg::*;
(
  input  slot_t slot_i,
  input  slot_t cand_i,
  input  logic  cand_valid_i,
  input  logic  is_gbc_i,
  output slot_t merged_c_o
);

  logic take_c;

  always_comb begin
    take_c = 1'b0;
    if (cand_valid_i && (cand_i.color != '0)) begin
      take_c = (slot_i.color == '0) || (is_gbc_i && (cand_i.index < slot_i.index));
    end
    merged_c_o = take_c ? cand_i : slot_i;
  end

endmodule

// File: rtl/sprite_pixel_fifo.sv
// 8-slot sprite pixel shifter: merges fetched sprite rows and streams one
// sprite pixel per pixel clock to the mixer.
module sprite_pixel_fifo
  import sprite_pixel_fifo_pkg::*;
(
  input logic              clk,
  input logic              reset,
  sprite_pixel_fifo_if.slave bus
);

  slot_t            slot_q    [DEPTH];
  slot_t            slot_d    [DEPTH];
  slot_t            shifted_c [DEPTH];
  slot_t            cand_c    [DEPTH];
  slot_t            merged_c  [DEPTH];
  logic [DEPTH-1:0] cand_valid_c;

  // Shift happens before the merge so a same-cycle load targets the advanced slots
  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      shifted_c[k] = slot_q[k];
    end
    if (bus.shift) begin
      for (int k = 0; k < int'(DEPTH) - 1; k++) begin
        shifted_c[k] = slot_q[k+1];
      end
      shifted_c[DEPTH-1] = TRANSPARENT;
    end
  end

  // Slot s receives row pixel s + load_skip; pixels pushed past the right end are dropped
  always_comb begin
    logic [3:0] p;
    cand_valid_c = '0;
    for (int s = 0; s < int'(DEPTH); s++) begin
      p                 = 4'(s) + 4'(bus.load_skip);
      cand_c[s].color   = row_pixel(bus.load_lo, bus.load_hi, bus.load_attr[ATTR_XFLIP], p[2:0]);
      cand_c[s].palette = attr_palette(bus.load_attr, bus.isGBC);
      cand_c[s].bg_prio = bus.load_attr[ATTR_PRIO];
      cand_c[s].index   = bus.load_index;
      cand_valid_c[s]   = bus.load && (p < 4'(DEPTH));
    end
  end

  for (genvar s = 0; s < int'(DEPTH); s++) begin : g_merge
    sprite_slot_merge u_merge (
      .slot_i       (shifted_c[s]),
      .cand_i       (cand_c[s]),
      .cand_valid_i (cand_valid_c[s]),
      .is_gbc_i     (bus.isGBC),
      .merged_c_o   (merged_c[s])
    );
  end

  always_comb begin
    for (int k = 0; k < int'(DEPTH); k++) begin
      slot_d[k] = bus.line_reset ? TRANSPARENT : merged_c[k];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        slot_q[k] <= TRANSPARENT;
      end
    end else if (bus.ce) begin
      for (int k = 0; k < int'(DEPTH); k++) begin
        slot_q[k] <= slot_d[k];
      end
    end
  end

  assign bus.pix_color   = slot_q[0].color;
  assign bus.pix_opaque  = (slot_q[0].color != '0);
  assign bus.pix_palette = slot_q[0].palette;
  assign bus.pix_bg_prio = slot_q[0].bg_prio;

endmodule

// File: tb/tb_sprite_pixel_fifo.sv
// Directed bench for sprite_pixel_fifo: row extraction, xflip, skip,
// DMG/GBC overlap, load+shift ordering, line_reset priority and ce gating.
module tb_sprite_pixel_fifo;

  logic clk;
  logic reset;
  int   errors;
  int   checks;

  sprite_pixel_fifo_if bus ();

  sprite_pixel_fifo dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [7:0] lo, input logic [7:0] hi, input logic [7:0] attr,
                         input logic [3:0] idx, input logic [2:0] skip);
    bus.load_lo    = lo;
    bus.load_hi    = hi;
    bus.load_attr  = attr;
    bus.load_index = idx;
    bus.load_skip  = skip;
    bus.load       = 1'b1;
    tick();
    bus.load       = 1'b0;
  endtask

  // exp_row holds pixel 0 in bits 15:14 through pixel 7 in bits 1:0
  task automatic check_row(input string tag, input logic [15:0] exp_row);
    int e;
    for (int i = 0; i < 8; i++) begin
      e = int'(exp_row[15-2*i -: 2]);
      check($sformatf("%s color[%0d]", tag, i), int'(bus.pix_color), e);
      check($sformatf("%s opaque[%0d]", tag, i), int'(bus.pix_opaque), int'(e != 0));
      bus.shift = 1'b1;
      tick();
      bus.shift = 1'b0;
    end
  endtask

  initial begin
    errors          = 0;
    checks          = 0;
    reset           = 1'b1;
    bus.ce          = 1'b1;
    bus.isGBC       = 1'b0;
    bus.line_reset  = 1'b0;
    bus.load        = 1'b0;
    bus.load_lo     = '0;
    bus.load_hi     = '0;
    bus.load_attr   = '0;
    bus.load_index  = '0;
    bus.load_skip   = '0;
    bus.shift       = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("reset color", int'(bus.pix_color), 0);
    check("reset palette", int'(bus.pix_palette), 0);
    check("reset bg_prio", int'(bus.pix_bg_prio), 0);
    check_row("empty", 16'h0000);

    // lo=F0: pixels 0-3 colour 1
    do_load(8'hF0, 8'h00, 8'h00, 4'd0, 3'd0);
    check_row("plain", 16'b01_01_01_01_00_00_00_00);

    do_load(8'hF0, 8'h00, 8'h20, 4'd0, 3'd0);
    check_row("xflip", 16'b00_00_00_00_01_01_01_01);

    // DMG: first fetched sprite keeps every overlapping pixel
    bus.isGBC = 1'b0;
    do_load(8'hFF, 8'h00, 8'h10, 4'd3, 3'd0);
    do_load(8'h00, 8'hFF, 8'h85, 4'd1, 3'd0);
    check("dmg palette", int'(bus.pix_palette), 1);
    check("dmg bg_prio", int'(bus.pix_bg_prio), 0);
    check_row("dmg overlap", 16'h5555);

    // GBC: lower OAM index takes over, palette from attr[2:0]
    bus.isGBC = 1'b1;
    do_load(8'hFF, 8'h00, 8'h10, 4'd3, 3'd0);
    do_load(8'h00, 8'hFF, 8'h85, 4'd1, 3'd0);
    check("gbc palette", int'(bus.pix_palette), 5);
    check("gbc bg_prio", int'(bus.pix_bg_prio), 1);
    check_row("gbc overlap", 16'hAAAA);
    bus.isGBC = 1'b0;

    do_load(8'hFF, 8'hFF, 8'h00, 4'd0, 3'd5);
    check_row("skip5", 16'b11_11_11_00_00_00_00_00);

    // Row 0x40/0x80 gives slot0=2, slot1=1; same-cycle shift+load leaves slot1's 1 in front
    do_load(8'h40, 8'h80, 8'h00, 4'd0, 3'd0);
    check("pre-shift slot0", int'(bus.pix_color), 2);
    bus.shift = 1'b1;
    do_load(8'h00, 8'hFF, 8'h00, 4'd0, 3'd0);
    bus.shift = 1'b0;
    check_row("load+shift", 16'b01_10_10_10_10_10_10_10);

    // line_reset beats a simultaneous load
    do_load(8'hFF, 8'hFF, 8'h00, 4'd0, 3'd0);
    check("pre-lr slot0", int'(bus.pix_color), 3);
    bus.line_reset = 1'b1;
    do_load(8'hFF, 8'hFF, 8'h00, 4'd0, 3'd0);
    bus.line_reset = 1'b0;
    check_row("line_reset+load", 16'h0000);

    // Load and shift are ignored without ce
    do_load(8'hFF, 8'h00, 8'h00, 4'd0, 3'd0);
    bus.ce = 1'b0;
    bus.shift = 1'b1;
    do_load(8'h00, 8'hFF, 8'h00, 4'd0, 3'd0);
    bus.shift = 1'b0;
    check("ce=0 hold color", int'(bus.pix_color), 1);

    // Reset still clears without ce
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("reset no ce color", int'(bus.pix_color), 0);
    bus.ce = 1'b1;
    check_row("after reset", 16'h0000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
